strided_mem_stage: RTL and testbench

STRIDED_MEM_STAGE -- requirements
Module: strided_mem_stage

---
 rtl/strided_mem_stage.sv | 163 ++++++++++++++++
 tb/tb_strided_mem_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/strided_mem_stage.sv
// strided_mem_stage: strided vector/scalar load-store engine.
// Each transfer moves N elements (N=1 scalar, N=I vector) across P memory
// lanes per beat. Beat k, lane j carries element e=k*P+j at base+e*stride
// (mod 2^A). Loads capture lane data one cycle after the address beat.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   start_i            request strobe, honoured only in IDLE
//   op_vec_i           0 = scalar, 1 = vector
//   write_i            1 = store, 0 = load
//   op_source_i        store source: 1 = ALU, 0 = rd2
//   base_addr_i        element 0 address
//   stride_i           unsigned address step between elements
//   alu_vec_i/rd2_vec_i, alu_sca_i/rd2_sca_i   store data sources
//   mem_addr_o/mem_wdata_o/mem_wren_o          per-lane memory request
//   mem_rdata_i        per-lane read data, one cycle after its address
//   busy_o, done_o     status; done_o pulses for one cycle
//   scalar_o, vector_o load results, held until the next load
module strided_mem_stage #(
  parameter int I = 20,
  parameter int L = 8,
  parameter int A = 32,
  parameter int P = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           op_vec_i,
  input  logic           write_i,
  input  logic           op_source_i,
  input  logic [A-1:0]   base_addr_i,
  input  logic [A-1:0]   stride_i,
  input  logic [I*L-1:0] alu_vec_i,
  input  logic [I*L-1:0] rd2_vec_i,
  input  logic [L-1:0]   alu_sca_i,
  input  logic [L-1:0]   rd2_sca_i,
  output logic [P*A-1:0] mem_addr_o,
  output logic [P*L-1:0] mem_wdata_o,
  output logic [P-1:0]   mem_wren_o,
  input  logic [P*L-1:0] mem_rdata_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [L-1:0]   scalar_o,
  output logic [I*L-1:0] vector_o
);

  localparam int BV = (I + P - 1) / P;
  localparam int BW = $clog2(BV + 1);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d, last_beat;
  logic           op_vec_q, write_q;
  logic [A-1:0]   base_q, stride_q;
  logic [I*L-1:0] wdata_q;
  logic           vld_p1;
  logic [BW-1:0]  beat_p1;
  int             n_elem;
  int             e;

  wire accept = (state_q == IDLE) && start_i;

  assign n_elem    = op_vec_q ? I : 1;
  assign last_beat = op_vec_q ? BW'(BV - 1) : '0;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);

  // Control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      op_vec_q <= 1'b0;
      write_q  <= 1'b0;
      vld_p1   <= 1'b0;
      beat_p1  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (accept) begin
        op_vec_q <= op_vec_i;
        write_q  <= write_i;
      end
      vld_p1  <= (state_q == XFER) && !write_q;
      beat_p1 <= beat_q;
    end
  end

  // Operand latch: only observed while the FSM is out of IDLE, so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      base_q   <= base_addr_i;
      stride_q <= stride_i;
      if (op_vec_i)
        wdata_q <= op_source_i ? alu_vec_i : rd2_vec_i;
      else
        wdata_q <= (I*L)'(op_source_i ? alu_sca_i : rd2_sca_i);
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = XFER;
          beat_d  = '0;
        end
      end
      XFER: begin
        if (beat_q == last_beat) begin
          beat_d  = '0;
          state_d = write_q ? DONE : DRAIN;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: per-lane request for the current beat. With a zero stride
  // every element hits the same address, so only the final element is
  // written and the last element wins.
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wren_o  = '0;
    e           = 0;
    for (int j = 0; j < P; j++) begin
      e = int'(beat_q) * P + j;
      if ((state_q == XFER) && (e < n_elem)) begin
        mem_addr_o[j*A +: A] = base_q + A'(e) * stride_q;
        if (write_q) begin
          mem_wdata_o[j*L +: L] = wdata_q[e*L +: L];
          mem_wren_o[j]         = (stride_q != '0) || (e == n_elem - 1);
        end
      end
    end
  end

  // Stage p1: read data returns one cycle after its beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scalar_o <= '0;
      vector_o <= '0;
    end else if (vld_p1) begin
      for (int j = 0; j < P; j++) begin
        if (int'(beat_p1) * P + j < n_elem) begin
          if (op_vec_q)
            vector_o[(int'(beat_p1) * P + j) * L +: L] <= mem_rdata_i[j*L +: L];
          else
            scalar_o <= mem_rdata_i[j*L +: L];
        end
      end
    end
  end

endmodule

// File: tb/tb_strided_mem_stage.sv
// Testbench for strided_mem_stage: table of operations checked cycle by
// cycle against a queue of expected per-cycle lane outputs, plus hand
// sequences for mid-operation reset and a P=3 wrap-around load.
module tb_strided_mem_stage;

  localparam int I  = 20;
  localparam int L  = 8;
  localparam int A  = 32;
  localparam int P  = 4;
  localparam int P3 = 3;

  typedef struct {
    bit          vec;
    bit          wr;
    bit          src;
    logic [31:0] base;
    logic [31:0] stride;
    bit          poke;
    int          exp_lat;
  } op_t;

  typedef struct packed {
    logic [P*A-1:0] addr;
    logic [P*L-1:0] wdata;
    logic [P-1:0]   wren;
    logic           busy;
    logic           done;
  } cyc_t;

  logic clk = 1'b0;
  logic rst;
  logic start, start3, op_vec, write, op_source;
  logic [A-1:0]   base, stride;
  logic [I*L-1:0] alu_vec, rd2_vec;
  logic [L-1:0]   alu_sca, rd2_sca;

  logic [P*A-1:0] mem_addr;
  logic [P*L-1:0] mem_wdata, mem_rdata;
  logic [P-1:0]   mem_wren;
  logic           busy, done;
  logic [L-1:0]   scalar;
  logic [I*L-1:0] vector;

  logic [P3*A-1:0] mem_addr3;
  logic [P3*L-1:0] mem_wdata3, mem_rdata3;
  logic [P3-1:0]   mem_wren3;
  logic            busy3, done3;
  logic [L-1:0]    scalar3;
  logic [I*L-1:0]  vector3;

  int n_chk  = 0;
  int n_fail = 0;
  cyc_t sb[$];
  logic [I*L-1:0] exp_vec;
  logic [L-1:0]   exp_sca;
  op_t ops[8];

  always #5 clk = ~clk;

  strided_mem_stage #(.I(I), .L(L), .A(A), .P(P)) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .op_vec_i(op_vec), .write_i(write),
    .op_source_i(op_source), .base_addr_i(base), .stride_i(stride),
    .alu_vec_i(alu_vec), .rd2_vec_i(rd2_vec), .alu_sca_i(alu_sca), .rd2_sca_i(rd2_sca),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wren_o(mem_wren),
    .mem_rdata_i(mem_rdata), .busy_o(busy), .done_o(done),
    .scalar_o(scalar), .vector_o(vector)
  );

  strided_mem_stage #(.I(I), .L(L), .A(A), .P(P3)) u_dut3 (
    .clk(clk), .rst(rst), .start_i(start3), .op_vec_i(op_vec), .write_i(write),
    .op_source_i(op_source), .base_addr_i(base), .stride_i(stride),
    .alu_vec_i(alu_vec), .rd2_vec_i(rd2_vec), .alu_sca_i(alu_sca), .rd2_sca_i(rd2_sca),
    .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_wren_o(mem_wren3),
    .mem_rdata_i(mem_rdata3), .busy_o(busy3), .done_o(done3),
    .scalar_o(scalar3), .vector_o(vector3)
  );

  // Memory contents are a fixed function of address: mem[0x40] = 0xA5
  function automatic logic [7:0] fn(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hE5;
  endfunction

  // Registered read port: data valid one cycle after the address
  always @(posedge clk) begin
    for (int j = 0; j < P; j++)  mem_rdata[j*L +: L]  <= fn(mem_addr[j*A +: A]);
    for (int j = 0; j < P3; j++) mem_rdata3[j*L +: L] <= fn(mem_addr3[j*A +: A]);
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic randomize_data();
    for (int e = 0; e < I; e++) begin
      alu_vec[e*L +: L] = 8'($urandom);
      rd2_vec[e*L +: L] = 8'($urandom);
    end
    alu_sca = 8'($urandom);
    rd2_sca = 8'($urandom);
  endtask

  task automatic scramble();
    randomize_data();
    base      = $urandom;
    stride    = $urandom;
    op_vec    = 1'($urandom);
    write     = 1'($urandom);
    op_source = 1'($urandom);
  endtask

  // Called at a negedge; returns at the negedge of the idle cycle after DONE
  task automatic run_op(input op_t op, input int idx);
    int n, b, cnt, e;
    logic [L-1:0] d[I];
    cyc_t r;
    n = op.vec ? I : 1;
    b = (n + P - 1) / P;
    randomize_data();
    op_vec = op.vec; write = op.wr; op_source = op.src;
    base = op.base; stride = op.stride;
    for (int k = 0; k < I; k++) begin
      if (op.vec) d[k] = op.src ? alu_vec[k*L +: L] : rd2_vec[k*L +: L];
      else        d[k] = op.src ? alu_sca : rd2_sca;
    end
    for (int c = 1; c <= op.exp_lat + 1; c++) begin
      r = '0;
      r.busy = (c <= op.exp_lat);
      r.done = (c == op.exp_lat);
      if (c <= b) begin
        for (int j = 0; j < P; j++) begin
          e = (c - 1) * P + j;
          if (e < n) begin
            r.addr[j*A +: A] = op.base + 32'(e) * op.stride;
            if (op.wr) begin
              r.wdata[j*L +: L] = d[e];
              r.wren[j] = (op.stride != 0) || (e == n - 1);
            end
          end
        end
      end
      sb.push_back(r);
    end
    if (!op.wr) begin
      if (op.vec)
        for (int k = 0; k < I; k++) exp_vec[k*L +: L] = fn(op.base + 32'(k) * op.stride);
      else
        exp_sca = fn(op.base);
    end
    start = 1'b1;
    cnt = 0;
    while (sb.size() > 0 && cnt < 64) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
      start = op.poke && (cnt == 2);
      if (cnt == 1) scramble();
      r = sb.pop_front();
      chk($sformatf("op%0d.c%0d.addr", idx, cnt), 256'(mem_addr), 256'(r.addr));
      chk($sformatf("op%0d.c%0d.wdata", idx, cnt), 256'(mem_wdata), 256'(r.wdata));
      chk($sformatf("op%0d.c%0d.wren", idx, cnt), 256'(mem_wren), 256'(r.wren));
      chk($sformatf("op%0d.c%0d.busy", idx, cnt), 256'(busy), 256'(r.busy));
      chk($sformatf("op%0d.c%0d.done", idx, cnt), 256'(done), 256'(r.done));
      if (sb.size() == 0) begin
        chk($sformatf("op%0d.vector", idx), 256'(vector), 256'(exp_vec));
        chk($sformatf("op%0d.scalar", idx), 256'(scalar), 256'(exp_sca));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int done_cyc;
    logic [I*L-1:0] exp3;
    ops[0] = '{1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h1,  1'b1, 6};
    ops[1] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h5,  1'b0, 6};
    ops[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h2,  1'b0, 7};
    ops[3] = '{1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h9,  1'b0, 3};
    ops[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0080, 32'h3,  1'b0, 2};
    ops[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h0,  1'b1, 6};
    ops[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_0090, 32'h7,  1'b0, 2};
    ops[7] = '{1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'h10, 1'b0, 7};

    rst = 1'b0; start = 1'b0; start3 = 1'b0;
    op_vec = 1'b0; write = 1'b0; op_source = 1'b0;
    base = '0; stride = '0;
    randomize_data();
    exp_vec = '0; exp_sca = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy",   256'(busy),      256'(0));
    chk("rst.done",   256'(done),      256'(0));
    chk("rst.wren",   256'(mem_wren),  256'(0));
    chk("rst.addr",   256'(mem_addr),  256'(0));
    chk("rst.wdata",  256'(mem_wdata), 256'(0));
    chk("rst.vector", 256'(vector),    256'(0));
    chk("rst.scalar", 256'(scalar),    256'(0));
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_op(ops[i], i);
    chk("scalar.hold_a5", 256'(scalar), 256'(8'hA5));

    // Reset in the middle of a vector store (beat 2)
    randomize_data();
    op_vec = 1'b1; write = 1'b1; op_source = 1'b1;
    base = 32'h500; stride = 32'h4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("midrst.pre_wren",  256'(mem_wren), 256'(4'hF));
    chk("midrst.pre_addr0", 256'(mem_addr[31:0]), 256'(32'h520));
    rst = 1'b0;
    #1;
    chk("midrst.wren",   256'(mem_wren),  256'(0));
    chk("midrst.addr",   256'(mem_addr),  256'(0));
    chk("midrst.wdata",  256'(mem_wdata), 256'(0));
    chk("midrst.busy",   256'(busy),      256'(0));
    chk("midrst.done",   256'(done),      256'(0));
    chk("midrst.vector", 256'(vector),    256'(0));
    chk("midrst.scalar", 256'(scalar),    256'(0));
    exp_vec = '0; exp_sca = '0;
    @(negedge clk);
    rst = 1'b1;
    run_op('{1'b1, 1'b1, 1'b0, 32'h600, 32'h2, 1'b0, 6}, 8);

    // P=3 vector load wrapping past 2^32
    op_vec = 1'b1; write = 1'b0; op_source = 1'b0;
    base = 32'hFFFF_FFF0; stride = 32'h3; start3 = 1'b1;
    done_cyc = 0;
    for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      start3 = 1'b0;
      if (c == 3) chk("p3.e6_addr", 256'(mem_addr3[31:0]), 256'(32'h2));
      if (c == 7) begin
        chk("p3.last_addr", 256'(mem_addr3), 256'({32'h0, 32'h29, 32'h26}));
        chk("p3.last_wren", 256'(mem_wren3), 256'(0));
      end
      if (done3) done_cyc = c;
    end
    chk("p3.done_cycle", 256'(done_cyc), 256'(9));
    for (int k = 0; k < I; k++) exp3[k*L +: L] = fn(32'hFFFF_FFF0 + 32'(k) * 32'h3);
    chk("p3.vector", 256'(vector3), 256'(exp3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
